fir_capture_buffer: RTL and testbench
=====================================

# fir_capture_buffer

- Synthesizable response-capture block that sits on the output of the FIR filter.
- After an arm pulse it skips a programmable number of enabled cycles, then records a fixed-length block of signed filter output samples into on-chip memory.
- It then streams the block out over a valid/ready read port for host or logging logic.
- It is the in-hardware reader for the filter's output stream: it replaces file dumping of step/impulse responses.

## Interface
- DATA_W, 14: sample width, two's-complement signed.
- DEPTH, 100: samples captured per arm; range 2..2^ADDR_W.
- ADDR_W, 7: index width; DEPTH ≤ 2^ADDR_W.
- SKIP, 0: enabled cycles discarded after arm before capture starts; range 0..255.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  sample-rate enable, same signal that drives the filter.
- arm  in  1  start request; sampled only in IDLE.
- sample_in  in  DATA_W  signed sample, connected to filter_out.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final read transfer.
- rd_valid  out  1  rd_data/rd_index/rd_last are valid.
- rd_ready  in  1  consumer accepts the word.
- rd_data  out  DATA_W  captured sample.
- rd_index  out  ADDR_W  sample index, 0..DEPTH-1.
- rd_last  out  1  high with rd_valid when rd_index = DEPTH-1.

## Operation
- States: IDLE, SKIP, CAPTURE, FETCH, PRESENT.
- IDLE: on arm=1, go to SKIP if SKIP>0, else CAPTURE. Clear the write pointer and the skip counter. clk_enable is not required to arm.
- SKIP: the counter increments only when clk_enable=1. On the SKIP-th enabled cycle, go to CAPTURE.
- CAPTURE: on each edge with clk_enable=1, write sample_in to mem[wr_ptr] and increment wr_ptr. With clk_enable=0, nothing is written and nothing changes. After the DEPTH-th write, go to FETCH with rd_ptr=0. The pointer never wraps.
- FETCH: synchronous memory read of mem[rd_ptr]. Always lasts exactly one cycle, then go to PRESENT.
- PRESENT: rd_valid=1. rd_data, rd_index and rd_last stay stable until rd_valid&&rd_ready.
  - On transfer when rd_ptr<DEPTH-1: increment rd_ptr and go to FETCH.
  - On transfer when rd_ptr=DEPTH-1: go to IDLE and pulse done.
- The read side ignores clk_enable.
- arm outside IDLE is ignored and is not queued.
- Samples are stored bit-exact. No arithmetic is performed on the data path.
- Reset in any state:
  - Next cycle is IDLE with every output 0.
  - A partial capture is discarded, no done pulse is issued, and memory contents are don't-care.

## Timing
- Reset values: busy=0, done=0, rd_valid=0, rd_data=0, rd_index=0, rd_last=0. With CAPTURE_PEAK_EN: peak_max=0, peak_min=0, peak_valid=0.
- Arm accepted at edge E:
  - busy=1 from E+1.
  - With SKIP=0 and clk_enable held high, the first sample written is sample_in at edge E+1. The last is at edge E+DEPTH.
  - With clk_enable held high and SKIP>0, capture starts SKIP cycles later.
- First rd_valid is 2 cycles after the edge of the last write: one cycle in FETCH, then PRESENT.
- Throughput is one word per 2 cycles; consecutive rd_valid always has one bubble between words.
- done is asserted in the cycle after the final transfer edge. busy=0 in that same cycle, and a new arm is accepted in that cycle.
- Minimum arm-to-done with clk_enable held high, SKIP=0 and rd_ready held high is DEPTH + 2·DEPTH + 1 cycles.

## Configuration
- CAPTURE_PEAK_EN:
  - Defined: adds outputs peak_max (DATA_W, signed), peak_min (DATA_W, signed) and peak_valid (1).
    - The first captured sample loads both peak registers.
    - Each later captured sample updates them by signed compare.
    - peak_valid rises with the first FETCH and holds until the next accepted arm or reset.
    - Accepted arm clears peak_valid and both peak registers to 0.
  - Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Step: DEPTH=100, SKIP=0, sample_in=7373 constant, clk_enable=1, arm once, rd_ready=1 -> 100 words, all rd_data=7373, rd_index 0..99, rd_last only at 99, done pulses once.
- Backpressure and ramp: sample_in=-5+n per enabled cycle; hold rd_ready=0 for 5 cycles at index 3 -> rd_data=-2 and rd_index=3 stable throughout, no word lost. With CAPTURE_PEAK_EN: peak_min=-5, peak_max=94.
- Skip and enable: SKIP=4, clk_enable toggling 1,0 each cycle, sample_in=cycle count -> first stored sample is the 5th enabled cycle's value; only enabled-cycle values are stored.
- Arm while busy: second arm pulse during CAPTURE and again during PRESENT -> ignored, exactly one 100-word readout, one done.
- Reset mid-capture: assert reset after 40 writes -> IDLE next cycle, busy=0, no rd_valid, no done. A fresh arm then yields a full, correct 100-word capture.

Source files
------------

// File: rtl/fir_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fir_capture_buffer
// Description : Arm-triggered capture of signed FIR output samples into RAM,
//               then streamed back over a valid/ready read port.
//               Optional feature macro: CAPTURE_PEAK_EN (running min/max).
// Revision    : 1.0  initial release
// ============================================================================
module fir_capture_buffer #(
   parameter int DATA_W = 14,
   parameter int DEPTH  = 100,
   parameter int ADDR_W = 7,
   parameter int SKIP   = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_enable,
   input  logic                     arm,
   input  logic signed [DATA_W-1:0] sample_in,
   output logic                     busy,
   output logic                     done,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic        [DATA_W-1:0] rd_data,
   output logic        [ADDR_W-1:0] rd_index,
   output logic                     rd_last
`ifdef CAPTURE_PEAK_EN
   ,
   output logic signed [DATA_W-1:0] peak_max,
   output logic signed [DATA_W-1:0] peak_min,
   output logic                     peak_valid
`endif
);

   localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(DEPTH - 1);
   localparam logic [7:0]        c_SKIP_LAST = 8'((SKIP > 0) ? (SKIP - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SKIP    = 3'd1,
      S_CAPTURE = 3'd2,
      S_FETCH   = 3'd3,
      S_PRESENT = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [7:0]        r_skip_cnt;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_done;

   logic w_arm_ok;
   logic w_write;
   logic w_last_write;
   logic w_skip_done;
   logic w_xfer;
   logic w_xfer_last;

   assign w_arm_ok     = (r_state == S_IDLE) && arm;
   assign w_write      = (r_state == S_CAPTURE) && clk_enable;
   assign w_last_write = w_write && (r_wr_ptr == c_LAST_IDX);
   assign w_skip_done  = (r_state == S_SKIP) && clk_enable && (r_skip_cnt == c_SKIP_LAST);
   assign w_xfer       = (r_state == S_PRESENT) && rd_ready;
   assign w_xfer_last  = w_xfer && (r_rd_ptr == c_LAST_IDX);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (arm) begin
               w_next = (SKIP > 0) ? S_SKIP : S_CAPTURE;
            end
         end
         S_SKIP: begin
            if (w_skip_done) begin
               w_next = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (w_last_write) begin
               w_next = S_FETCH;
            end
         end
         S_FETCH: begin
            w_next = S_PRESENT;
         end
         S_PRESENT: begin
            if (w_xfer) begin
               w_next = w_xfer_last ? S_IDLE : S_FETCH;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // RAM array carries no reset so it can map onto block memory.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= sample_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_skip_cnt <= '0;
         r_rd_data  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_xfer_last;
         if (w_arm_ok) begin
            r_wr_ptr   <= '0;
            r_skip_cnt <= '0;
         end
         if ((r_state == S_SKIP) && clk_enable) begin
            r_skip_cnt <= r_skip_cnt + 8'd1;
         end
         // Write pointer holds on the final slot instead of wrapping.
         if (w_write && !w_last_write) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_last_write) begin
            r_rd_ptr <= '0;
         end
         if (w_xfer && !w_xfer_last) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (r_state == S_FETCH) begin
            r_rd_data <= r_mem[r_rd_ptr];
         end
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign rd_valid = (r_state == S_PRESENT);
   assign rd_data  = r_rd_data;
   assign rd_index = r_rd_ptr;
   assign rd_last  = (r_state == S_PRESENT) && (r_rd_ptr == c_LAST_IDX);

`ifdef CAPTURE_PEAK_EN
   logic signed [DATA_W-1:0] r_peak_max;
   logic signed [DATA_W-1:0] r_peak_min;
   logic                     r_peak_valid;
   logic                     r_peak_first;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_peak_max   <= '0;
         r_peak_min   <= '0;
         r_peak_valid <= 1'b0;
         r_peak_first <= 1'b0;
      end else if (w_arm_ok) begin
         r_peak_max   <= '0;
         r_peak_min   <= '0;
         r_peak_valid <= 1'b0;
         r_peak_first <= 1'b1;
      end else begin
         if (w_write) begin
            r_peak_first <= 1'b0;
            if (r_peak_first) begin
               r_peak_max <= sample_in;
               r_peak_min <= sample_in;
            end else begin
               if (sample_in > r_peak_max) begin
                  r_peak_max <= sample_in;
               end
               if (sample_in < r_peak_min) begin
                  r_peak_min <= sample_in;
               end
            end
         end
         if (r_state == S_FETCH) begin
            r_peak_valid <= 1'b1;
         end
      end
   end

   assign peak_max   = r_peak_max;
   assign peak_min   = r_peak_min;
   assign peak_valid = r_peak_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_capture_buffer
// Description : Scoreboard bench for fir_capture_buffer (SKIP=0 and SKIP=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fir_capture_buffer;

   localparam int DW  = 14;
   localparam int DEP = 100;
   localparam int AW  = 7;

   typedef logic [DW+AW:0] word_t;   // {data, index, last}

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset;
   logic                 ce    [2];
   logic                 arm   [2];
   logic                 rdy   [2];
   logic signed [DW-1:0] sin   [2];
   logic                 busy  [2];
   logic                 done  [2];
   logic                 vld   [2];
   logic                 rlast [2];
   logic        [DW-1:0] rdata [2];
   logic        [AW-1:0] ridx  [2];
`ifdef CAPTURE_PEAK_EN
   logic signed [DW-1:0] pmax [2];
   logic signed [DW-1:0] pmin [2];
   logic                 pvld [2];
`endif

   int checks = 0;
   int errs   = 0;

   fir_capture_buffer #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .SKIP(0)) u0 (
      .clk(clk), .reset(reset), .clk_enable(ce[0]), .arm(arm[0]), .sample_in(sin[0]),
      .busy(busy[0]), .done(done[0]), .rd_valid(vld[0]), .rd_ready(rdy[0]),
      .rd_data(rdata[0]), .rd_index(ridx[0]), .rd_last(rlast[0])
`ifdef CAPTURE_PEAK_EN
      , .peak_max(pmax[0]), .peak_min(pmin[0]), .peak_valid(pvld[0])
`endif
   );

   fir_capture_buffer #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .SKIP(4)) u1 (
      .clk(clk), .reset(reset), .clk_enable(ce[1]), .arm(arm[1]), .sample_in(sin[1]),
      .busy(busy[1]), .done(done[1]), .rd_valid(vld[1]), .rd_ready(rdy[1]),
      .rd_data(rdata[1]), .rd_index(ridx[1]), .rd_last(rlast[1])
`ifdef CAPTURE_PEAK_EN
      , .peak_max(pmax[1]), .peak_min(pmin[1]), .peak_valid(pvld[1])
`endif
   );

   // Reference model: predicts stored words from the driven stimulus and
   // records every observed read transfer.
   for (genvar g = 0; g < 2; g++) begin : g_sb
      localparam int SK = (g == 0) ? 0 : 4;
      word_t exp_q [$];
      word_t obs_q [$];
      int phase = 0;
      int nen   = 0;
      int wr    = 0;
      int nrd   = 0;
      int dones = 0;
      always @(negedge clk) begin
         if (vld[g] && rdy[g]) obs_q.push_back({rdata[g], ridx[g], rlast[g]});
         if (done[g]) dones <= dones + 1;
         if (reset) begin
            phase <= 0;
            exp_q.delete();
         end else begin
            case (phase)
               0: if (arm[g]) begin
                  phase <= 1; nen <= 0; wr <= 0;
               end
               1: if (ce[g]) begin
                  if (nen >= SK) begin
                     exp_q.push_back({sin[g], AW'(wr), (wr == DEP - 1)});
                     wr <= wr + 1;
                     if (wr == DEP - 1) begin
                        phase <= 2; nrd <= 0;
                     end
                  end
                  nen <= nen + 1;
               end
               2: if (vld[g] && rdy[g]) begin
                  nrd <= nrd + 1;
                  if (nrd == DEP - 1) phase <= 0;
               end
               default: phase <= 0;
            endcase
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) cyc();
      for (int u = 0; u < 2; u++) begin
         checks++;
         if ({busy[u], done[u], vld[u], rdata[u], ridx[u], rlast[u]} !== '0) begin
            errs++;
            $display("FAIL reset[%0d]: busy=%b done=%b vld=%b data=%h idx=%0d last=%b, want all 0",
                     u, busy[u], done[u], vld[u], rdata[u], ridx[u], rlast[u]);
         end
      end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_step();
      int n;
      int d0;
      word_t o, e;
      d0 = g_sb[0].dones;
      ce[0] = 1'b1; rdy[0] = 1'b1; sin[0] = 14'sd7373; arm[0] = 1'b1;
      n = 0;
      do begin
         cyc(); n++; arm[0] = 1'b0;
      end while (!done[0] && n < 2000);
      checks++;
      if (n !== 3 * DEP + 1) begin
         errs++;
         $display("FAIL step arm-to-done: got %0d cycles, want %0d", n, 3 * DEP + 1);
      end
      repeat (3) cyc();
      checks++;
      if (g_sb[0].dones - d0 !== 1) begin
         errs++;
         $display("FAIL step done count: got %0d, want 1", g_sb[0].dones - d0);
      end
      checks++;
      if (g_sb[0].obs_q.size() !== DEP) begin
         errs++;
         $display("FAIL step word count: got %0d, want %0d", g_sb[0].obs_q.size(), DEP);
      end
      while (g_sb[0].obs_q.size() > 0 && g_sb[0].exp_q.size() > 0) begin
         o = g_sb[0].obs_q.pop_front();
         e = g_sb[0].exp_q.pop_front();
         checks++;
         if (o !== e || o[DW+AW:AW+1] !== 14'd7373) begin
            errs++;
            $display("FAIL step word: got %h, want %h", o, e);
         end
      end
      g_sb[0].obs_q.delete(); g_sb[0].exp_q.delete();
   endtask

   task automatic test_backpressure();
      int k;
      bit held;
      word_t o, e;
      ce[0] = 1'b1; rdy[0] = 1'b1; arm[0] = 1'b1; sin[0] = '0;
      cyc();
      arm[0] = 1'b0;
      k = 0; held = 1'b0;
      while (!done[0] && k < 2000) begin
         sin[0] = 14'(k - 5);
         k++;
         if (!held && vld[0] && ridx[0] == 7'd3) begin
            held = 1'b1;
            rdy[0] = 1'b0;
            for (int j = 0; j < 5; j++) begin
               cyc();
               sin[0] = 14'(k - 5); k++;
               checks++;
               if (vld[0] !== 1'b1 || rdata[0] !== 14'h3FFE || ridx[0] !== 7'd3) begin
                  errs++;
                  $display("FAIL backpressure hold %0d: vld=%b data=%h idx=%0d, want vld=1 data=3ffe idx=3",
                           j, vld[0], rdata[0], ridx[0]);
               end
            end
            rdy[0] = 1'b1;
         end
         cyc();
      end
      checks++;
      if (!done[0] || !held) begin
         errs++;
         $display("FAIL backpressure timeout: done=%b held=%b, want both 1", done[0], held);
      end
`ifdef CAPTURE_PEAK_EN
      checks++;
      if (pmin[0] !== -14'sd5 || pmax[0] !== 14'sd94 || pvld[0] !== 1'b1) begin
         errs++;
         $display("FAIL peak: min=%0d max=%0d valid=%b, want -5 94 1", pmin[0], pmax[0], pvld[0]);
      end
`endif
      checks++;
      if (g_sb[0].obs_q.size() !== DEP) begin
         errs++;
         $display("FAIL backpressure word count: got %0d, want %0d", g_sb[0].obs_q.size(), DEP);
      end
      while (g_sb[0].obs_q.size() > 0 && g_sb[0].exp_q.size() > 0) begin
         o = g_sb[0].obs_q.pop_front();
         e = g_sb[0].exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errs++;
            $display("FAIL backpressure word: got %h, want %h", o, e);
         end
      end
      g_sb[0].obs_q.delete(); g_sb[0].exp_q.delete();
      cyc();
   endtask

   task automatic test_skip_enable();
      int c;
      word_t o, e;
      rdy[1] = 1'b1; ce[1] = 1'b0; sin[1] = '0; arm[1] = 1'b1;
      cyc();
      arm[1] = 1'b0;
      c = 0;
      while (!done[1] && c < 3000) begin
         sin[1] = 14'(c);
         ce[1]  = (c % 2 == 0);
         c++;
         cyc();
      end
      checks++;
      if (!done[1]) begin
         errs++;
         $display("FAIL skip timeout: done not seen in %0d cycles", c);
      end
      checks++;
      if (g_sb[1].obs_q.size() !== DEP) begin
         errs++;
         $display("FAIL skip word count: got %0d, want %0d", g_sb[1].obs_q.size(), DEP);
      end
      if (g_sb[1].obs_q.size() > 0) begin
         o = g_sb[1].obs_q[0];
         checks++;
         if (o[DW+AW:AW+1] !== 14'd8) begin
            errs++;
            $display("FAIL skip first sample: got %0d, want 8", o[DW+AW:AW+1]);
         end
      end
      while (g_sb[1].obs_q.size() > 0 && g_sb[1].exp_q.size() > 0) begin
         o = g_sb[1].obs_q.pop_front();
         e = g_sb[1].exp_q.pop_front();
         checks++;
         if (o !== e || o[AW+1] !== 1'b0) begin
            errs++;
            $display("FAIL skip word: got %h, want %h", o, e);
         end
      end
      g_sb[1].obs_q.delete(); g_sb[1].exp_q.delete();
      ce[1] = 1'b0;
      cyc();
   endtask

   task automatic test_arm_while_busy();
      int n;
      int d0;
      bit late_vld;
      word_t o, e;
      d0 = g_sb[0].dones;
      ce[0] = 1'b1; rdy[0] = 1'b1; arm[0] = 1'b1; sin[0] = 14'($urandom);
      n = 0;
      do begin
         cyc(); n++;
         sin[0] = 14'($urandom);
         arm[0] = (n == 30) || (vld[0] && ridx[0] == 7'd10);
      end while (!done[0] && n < 2000);
      arm[0] = 1'b0;
      late_vld = 1'b0;
      repeat (20) begin
         cyc();
         if (vld[0] || busy[0]) late_vld = 1'b1;
      end
      checks++;
      if (late_vld || g_sb[0].dones - d0 !== 1) begin
         errs++;
         $display("FAIL arm busy: extra activity=%b dones=%0d, want 0 and 1", late_vld, g_sb[0].dones - d0);
      end
      checks++;
      if (g_sb[0].obs_q.size() !== DEP) begin
         errs++;
         $display("FAIL arm busy word count: got %0d, want %0d", g_sb[0].obs_q.size(), DEP);
      end
      while (g_sb[0].obs_q.size() > 0 && g_sb[0].exp_q.size() > 0) begin
         o = g_sb[0].obs_q.pop_front();
         e = g_sb[0].exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errs++;
            $display("FAIL arm busy word: got %h, want %h", o, e);
         end
      end
      g_sb[0].obs_q.delete(); g_sb[0].exp_q.delete();
   endtask

   task automatic test_reset_mid_capture();
      int d0;
      int n;
      bit act;
      word_t o, e;
      d0 = g_sb[0].dones;
      ce[0] = 1'b1; rdy[0] = 1'b1; arm[0] = 1'b1;
      cyc();
      arm[0] = 1'b0;
      repeat (40) begin
         sin[0] = 14'($urandom);
         cyc();
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      checks++;
      if (busy[0] !== 1'b0 || vld[0] !== 1'b0 || done[0] !== 1'b0) begin
         errs++;
         $display("FAIL mid reset: busy=%b vld=%b done=%b, want 0 0 0", busy[0], vld[0], done[0]);
      end
      act = 1'b0;
      repeat (10) begin
         cyc();
         if (vld[0] || done[0] || busy[0]) act = 1'b1;
      end
      checks++;
      if (act || g_sb[0].obs_q.size() !== 0 || g_sb[0].dones !== d0) begin
         errs++;
         $display("FAIL mid reset idle: activity=%b words=%0d dones=%0d, want 0 0 0",
                  act, g_sb[0].obs_q.size(), g_sb[0].dones - d0);
      end
      arm[0] = 1'b1;
      n = 0;
      do begin
         cyc(); n++; arm[0] = 1'b0;
         sin[0] = 14'($urandom);
      end while (!done[0] && n < 2000);
      checks++;
      if (g_sb[0].obs_q.size() !== DEP || !done[0]) begin
         errs++;
         $display("FAIL mid reset recapture: words=%0d done=%b, want %0d 1", g_sb[0].obs_q.size(), done[0], DEP);
      end
      while (g_sb[0].obs_q.size() > 0 && g_sb[0].exp_q.size() > 0) begin
         o = g_sb[0].obs_q.pop_front();
         e = g_sb[0].exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errs++;
            $display("FAIL mid reset word: got %h, want %h", o, e);
         end
      end
      g_sb[0].obs_q.delete(); g_sb[0].exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      for (int u = 0; u < 2; u++) begin
         ce[u] = 1'b0; arm[u] = 1'b0; rdy[u] = 1'b1; sin[u] = '0;
      end
      test_reset();
      test_step();
      test_backpressure();
      test_skip_enable();
      test_arm_while_busy();
      test_reset_mid_capture();
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end

endmodule
`default_nettype wire
